// File: rtl/mig_block_responder_pkg.sv
// Shared definitions for the MIG block responder: FSM state encoding, MIG
// command codes and the cache block width.
package mig_block_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR0   = 3'd1,
    ST_WR1   = 3'd2,
    ST_RD0   = 3'd3,
    ST_RD1   = 3'd4,
    ST_RWAIT = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [2:0] MIG_CMD_WR = 3'b000;
  localparam logic [2:0] MIG_CMD_RD = 3'b001;
  localparam int         BLOCK_W    = 256;

  // The second beat of a block is addressed by the WR1/RD1 states.
  function automatic logic is_beat1(input state_t s);
    return (s == ST_WR1) || (s == ST_RD1);
  endfunction

endpackage

// File: rtl/mig_block_responder_sync_ff.sv
// STAGES-deep flop chain bringing the requester's ram_en level into ui_clk.
module mig_block_responder_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic ui_clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge ui_clk) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/mig_block_responder.sv
// Converts one 256-bit block request (4-phase ram_en/ram_rdy) into two 128-bit
// MIG app transactions. Optional debug ports under MIG_RESPONDER_DBG_EN.
module mig_block_responder
  import mig_block_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int APP_ADDR_W  = 27,
  parameter int BEAT_W      = 128
) (
  input  logic                  ui_clk,
  input  logic                  rst,
  input  logic                  ram_en,
  input  logic                  ram_write,
  input  logic [29:0]           ram_addr,
  input  logic [BLOCK_W-1:0]    data_to_ram,
  output logic                  ram_rdy,
  output logic [BLOCK_W-1:0]    block_from_ram,
  input  logic                  init_calib_complete,
  output logic [APP_ADDR_W-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [BEAT_W-1:0]     app_wdf_data,
  output logic [BEAT_W/8-1:0]   app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [BEAT_W-1:0]     app_rd_data,
  input  logic                  app_rd_data_valid
`ifdef MIG_RESPONDER_DBG_EN
  ,
  output logic [2:0]            ddr_ctrl_status,
  output logic [15:0]           xfer_count
`endif
);

  state_t            state, state_next;
  logic              en_sync;
  logic              advance, wr_state, rd_window, rd_take, beat_sel;
  logic              cmd_done, dat_done;
  logic [1:0]        rd_cnt;
  logic [22:0]       blk_q;
  logic              write_q;
  logic [BLOCK_W-1:0] data_q;
  logic [BEAT_W-1:0] rd_lo;
  logic              unused_addr_bits;

  mig_block_responder_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .ui_clk (ui_clk),
    .rst    (rst),
    .d      (ram_en),
    .q      (en_sync)
  );

  always_ff @(posedge ui_clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    state_next   = state;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    advance      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en_sync && init_calib_complete)
          state_next = ram_write ? ST_WR0 : ST_RD0;
      end
      ST_WR0, ST_WR1: begin
        // Command and data handshakes complete independently; move on once both have.
        app_en       = !cmd_done;
        app_wdf_wren = !dat_done;
        advance      = (cmd_done || app_rdy) && (dat_done || app_wdf_rdy);
        if (advance) state_next = (state == ST_WR0) ? ST_WR1 : ST_DONE;
      end
      ST_RD0, ST_RD1: begin
        app_en = 1'b1;
        if (app_rdy) state_next = (state == ST_RD0) ? ST_RD1 : ST_RWAIT;
      end
      ST_RWAIT: begin
        if (rd_cnt == 2'd2) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (!en_sync) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign wr_state  = (state == ST_WR0) || (state == ST_WR1);
  assign rd_window = (state == ST_RD0) || (state == ST_RD1) || (state == ST_RWAIT);
  assign rd_take   = rd_window && app_rd_data_valid && (rd_cnt != 2'd2);
  assign beat_sel  = is_beat1(state);

  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      cmd_done       <= 1'b0;
      dat_done       <= 1'b0;
      rd_cnt         <= 2'd0;
      blk_q          <= '0;
      write_q        <= 1'b0;
      block_from_ram <= '0;
    end else begin
      cmd_done <= wr_state && !advance && (cmd_done || app_rdy);
      dat_done <= wr_state && !advance && (dat_done || app_wdf_rdy);
      if (state == ST_IDLE && state_next != ST_IDLE) begin
        blk_q   <= ram_addr[25:3];
        write_q <= ram_write;
      end
      if (state == ST_IDLE)  rd_cnt <= 2'd0;
      else if (rd_take)      rd_cnt <= rd_cnt + 2'd1;
      // The visible block only changes when the whole new block has arrived.
      if (rd_take && rd_cnt == 2'd1) block_from_ram <= {app_rd_data, rd_lo};
    end
  end

  always_ff @(posedge ui_clk) begin
    // NOTE: pure data-holding registers carry no reset; they are always loaded before use.
    if (state == ST_IDLE && state_next != ST_IDLE) data_q <= data_to_ram;
    if (rd_take && rd_cnt == 2'd0) rd_lo <= app_rd_data;
  end

  assign ram_rdy          = (state == ST_DONE);
  assign app_cmd          = write_q ? MIG_CMD_WR : MIG_CMD_RD;
  assign app_addr         = APP_ADDR_W'({blk_q, beat_sel, 3'b000});
  assign app_wdf_data     = beat_sel ? data_q[BLOCK_W-1:BEAT_W] : data_q[BEAT_W-1:0];
  assign app_wdf_end      = app_wdf_wren;
  assign app_wdf_mask     = '0;
  assign unused_addr_bits = ^{ram_addr[29:26], ram_addr[2:0]};

`ifdef MIG_RESPONDER_DBG_EN
  assign ddr_ctrl_status = state;

  always_ff @(posedge ui_clk) begin
    if (!rst) xfer_count <= '0;
    else if (state != ST_DONE && state_next == ST_DONE) xfer_count <= xfer_count + 16'd1;
  end
`endif

endmodule
